// File: rtl/mem_seq_pkg.sv
// Shared types and constants for the memory access sequencer.
// Latencies count posedges from the accept edge (inclusive) to the first cycle rsp_valid is high.
package mem_seq_pkg;

   localparam int DEFAULT_ADDR_W = 3;
   localparam int DEFAULT_DATA_W = 8;

   localparam int RD_LAT     = 3;
   localparam int WR_LAT     = 3;
   localparam int WR_VFY_LAT = 5;

   typedef enum logic [2:0] {
      IDLE,
      WR_ISSUE,
      WR_HOLD,
      RD_ISSUE,
      RD_CAPT,
      RSP
   } state_t;

endpackage

// File: rtl/mem_seq_rsp_reg.sv
// Response holding register: loads a response, holds it under backpressure, clears on handshake.
module mem_seq_rsp_reg
   import mem_seq_pkg::*;
#(
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              clear,
   input  logic [DATA_W-1:0] load_data,
   input  logic              load_err,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end else if (load) begin
         rsp_valid <= 1'b1;
         rsp_data  <= load_data;
         rsp_err   <= load_err;
      end else if (clear) begin
         rsp_valid <= 1'b0;
         rsp_data  <= '0;
         rsp_err   <= 1'b0;
      end
   end

endmodule

// File: rtl/mem_access_sequencer.sv
// Single-request memory access sequencer driving a registered-enable memory.
// Optional MEM_SEQ_WRITE_VERIFY_EN: every write is read back and compared before responding.
module mem_access_sequencer
   import mem_seq_pkg::*;
#(
   parameter int ADDR_W = DEFAULT_ADDR_W,
   parameter int DATA_W = DEFAULT_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_adr,
   input  logic [DATA_W-1:0] req_data,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [DATA_W-1:0] rsp_data,
   output logic              rsp_err,
   output logic              mem_read,
   output logic              mem_write,
   output logic [ADDR_W-1:0] mem_adr,
   output logic [DATA_W-1:0] mem_inputs,
   input  logic [DATA_W-1:0] mem_outputs
);

   state_t            state;
   logic              rsp_load;
   logic              rsp_clear;
   logic              rsp_load_err;
   logic [DATA_W-1:0] rsp_load_data;

`ifdef MEM_SEQ_WRITE_VERIFY_EN
   logic              is_write;
`endif

   assign req_ready = (state == IDLE);
   assign rsp_clear = (state == RSP) && rsp_ready;

`ifdef MEM_SEQ_WRITE_VERIFY_EN
   // Writes and reads both finish through RD_CAPT; mem_inputs still holds the written word.
   assign rsp_load      = (state == RD_CAPT);
   assign rsp_load_data = mem_outputs;
   assign rsp_load_err  = is_write && (mem_outputs != mem_inputs);
`else
   assign rsp_load      = (state == WR_HOLD) || (state == RD_CAPT);
   assign rsp_load_data = (state == RD_CAPT) ? mem_outputs : '0;
   assign rsp_load_err  = 1'b0;
`endif

   // Sequencer FSM; the memory strobes are registered so each is high for exactly its issue state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         mem_read   <= 1'b0;
         mem_write  <= 1'b0;
         mem_adr    <= '0;
         mem_inputs <= '0;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
         is_write   <= 1'b0;
`endif
      end else begin
         mem_read  <= 1'b0;
         mem_write <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  mem_adr    <= req_adr;
                  mem_inputs <= req_data;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
                  is_write   <= req_write;
`endif
                  if (req_write) begin
                     state     <= WR_ISSUE;
                     mem_write <= 1'b1;
                  end else begin
                     state    <= RD_ISSUE;
                     mem_read <= 1'b1;
                  end
               end
            end
            WR_ISSUE: state <= WR_HOLD;
            WR_HOLD: begin
`ifdef MEM_SEQ_WRITE_VERIFY_EN
               state    <= RD_ISSUE;
               mem_read <= 1'b1;
`else
               state    <= RSP;
`endif
            end
            RD_ISSUE: state <= RD_CAPT;
            RD_CAPT:  state <= RSP;
            RSP: begin
               if (rsp_ready) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   mem_seq_rsp_reg #(
      .DATA_W (DATA_W)
   ) u_rsp_reg (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (rsp_load),
      .clear     (rsp_clear),
      .load_data (rsp_load_data),
      .load_err  (rsp_load_err),
      .rsp_valid (rsp_valid),
      .rsp_data  (rsp_data),
      .rsp_err   (rsp_err)
   );

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Self-checking bench for mem_access_sequencer with a registered-enable memory model.
// Expected write responses follow MEM_SEQ_WRITE_VERIFY_EN when the bench is built with it.
module tb_mem_access_sequencer;
   import mem_seq_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       req_valid = 1'b0;
   logic       req_ready;
   logic       req_write = 1'b0;
   logic [2:0] req_adr = '0;
   logic [7:0] req_data = '0;
   logic       rsp_valid;
   logic       rsp_ready = 1'b0;
   logic [7:0] rsp_data;
   logic       rsp_err;
   logic       mem_read;
   logic       mem_write;
   logic [2:0] mem_adr;
   logic [7:0] mem_inputs;
   logic [7:0] mem_outputs;

   int tests = 0;
   int failed = 0;
   int overlap_cnt = 0;
   bit stuck_en = 1'b0;

   typedef struct {
      logic [7:0] data;
      logic       err;
      int         lat;
   } sb_t;
   sb_t sb[$];

   typedef struct {
      logic       wr;
      logic [2:0] adr;
      logic [7:0] data;
      logic [7:0] exp_data;
      logic       exp_err;
      logic       hold;
   } vec_t;
   vec_t vecs[$];

   always #5 clk = ~clk;

   mem_access_sequencer #(.ADDR_W(3), .DATA_W(8)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_write   (req_write),
      .req_adr     (req_adr),
      .req_data    (req_data),
      .rsp_valid   (rsp_valid),
      .rsp_ready   (rsp_ready),
      .rsp_data    (rsp_data),
      .rsp_err     (rsp_err),
      .mem_read    (mem_read),
      .mem_write   (mem_write),
      .mem_adr     (mem_adr),
      .mem_inputs  (mem_inputs),
      .mem_outputs (mem_outputs)
   );

   // Memory model: registered read and write enables; optional stuck-at-0 on bit 7 of word 1.
   logic [7:0] mem [8];
   logic       rd_en_q = 1'b0;
   logic       wr_en_q = 1'b0;
   logic [2:0] rd_adr_q = '0;

   always @(posedge clk) begin
      rd_en_q  <= mem_read;
      rd_adr_q <= mem_adr;
      wr_en_q  <= mem_write;
      if (wr_en_q)
         mem[mem_adr] <= (stuck_en && mem_adr == 3'd1) ? (mem_inputs & 8'h7F) : mem_inputs;
   end

   assign mem_outputs = rd_en_q ? mem[rd_adr_q] : 8'h00;

   always @(negedge clk) begin
      if (mem_read && mem_write) overlap_cnt++;
   end

   function automatic logic [7:0] wr_rsp_data(input logic [7:0] d);
`ifdef MEM_SEQ_WRITE_VERIFY_EN
      return d;
`else
      return 8'h00;
`endif
   endfunction

   function automatic int wr_lat();
`ifdef MEM_SEQ_WRITE_VERIFY_EN
      return WR_VFY_LAT;
`else
      return WR_LAT;
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic check_output(input int lat, input logic [2:0] adr, input int stall);
      sb_t        exp;
      logic [7:0] held_data;
      exp = sb.pop_front();
      check("rsp_latency", lat, exp.lat);
      check("rsp_valid", rsp_valid, 1);
      check("rsp_data", rsp_data, exp.data);
      check("rsp_err", rsp_err, exp.err);
      check("busy_req_ready", req_ready, 0);
      check("mem_adr_held", mem_adr, adr);
      held_data = rsp_data;
      for (int k = 0; k < stall; k++) begin
         @(posedge clk);
         @(negedge clk);
         check("bp_rsp_valid", rsp_valid, 1);
         check("bp_rsp_data", rsp_data, held_data);
         check("bp_req_ready", req_ready, 0);
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rsp_ready = 1'b0;
      check("done_rsp_valid", rsp_valid, 0);
      check("done_req_ready", req_ready, 1);
   endtask

   task automatic apply_stimulus(input logic wr, input logic [2:0] adr, input logic [7:0] data,
                                 input logic [7:0] exp_data, input logic exp_err,
                                 input logic hold, input int stall);
      int lat;
      int n;
      sb.push_back('{data: exp_data, err: exp_err, lat: (wr ? wr_lat() : RD_LAT)});
      req_write = wr;
      req_adr   = adr;
      req_data  = data;
      req_valid = 1'b1;
      n = 0;
      while (!req_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("accept_ready", req_ready, 1);
      @(posedge clk);
      lat = 1;
      @(negedge clk);
      if (!hold) req_valid = 1'b0;
      while (!rsp_valid && lat < 20) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check_output(lat, adr, stall);
   endtask

   initial begin
      // Reset values are visible before the first clock edge.
      #1;
      check("reset_outputs", {mem_read, mem_write, rsp_valid, rsp_err, mem_adr, mem_inputs, rsp_data}, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("reset_req_ready", req_ready, 1);

      vecs.push_back('{1'b1, 3'd0, 8'h53, wr_rsp_data(8'h53), 1'b0, 1'b0});
      vecs.push_back('{1'b0, 3'd0, 8'h00, 8'h53, 1'b0, 1'b0});
      vecs.push_back('{1'b1, 3'd0, 8'h53, wr_rsp_data(8'h53), 1'b0, 1'b1});
      vecs.push_back('{1'b1, 3'd1, 8'h69, wr_rsp_data(8'h69), 1'b0, 1'b1});
      vecs.push_back('{1'b1, 3'd2, 8'h6E, wr_rsp_data(8'h6E), 1'b0, 1'b1});
      vecs.push_back('{1'b1, 3'd3, 8'h64, wr_rsp_data(8'h64), 1'b0, 1'b1});
      vecs.push_back('{1'b1, 3'd4, 8'h72, wr_rsp_data(8'h72), 1'b0, 1'b1});
      vecs.push_back('{1'b1, 3'd5, 8'h65, wr_rsp_data(8'h65), 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'd5, 8'hAA, 8'h65, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'd4, 8'hAA, 8'h72, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'd3, 8'hAA, 8'h64, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'd2, 8'hAA, 8'h6E, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'd1, 8'hAA, 8'h69, 1'b0, 1'b1});
      vecs.push_back('{1'b0, 3'd0, 8'hAA, 8'h53, 1'b0, 1'b1});

      foreach (vecs[i])
         apply_stimulus(vecs[i].wr, vecs[i].adr, vecs[i].data, vecs[i].exp_data,
                        vecs[i].exp_err, vecs[i].hold, 0);
      req_valid = 1'b0;

      // Backpressure on a read response.
      apply_stimulus(1'b0, 3'd3, 8'h00, 8'h64, 1'b0, 1'b0, 5);

      // Reset during WR_HOLD abandons the write with no response.
      req_write = 1'b1;
      req_adr   = 3'd2;
      req_data  = 8'h6E;
      req_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      req_valid = 1'b0;
      check("abort_mem_write", mem_write, 1);
      @(posedge clk);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_outputs", {mem_read, mem_write, rsp_valid, rsp_err, mem_adr, mem_inputs, rsp_data}, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         check("abort_no_rsp", rsp_valid, 0);
      end
      apply_stimulus(1'b0, 3'd4, 8'h00, 8'h72, 1'b0, 1'b0, 0);

      // Stuck bit on word 1: only the verifying build reports it.
      stuck_en = 1'b1;
`ifdef MEM_SEQ_WRITE_VERIFY_EN
      apply_stimulus(1'b1, 3'd1, 8'hFF, 8'h7F, 1'b1, 1'b0, 0);
`else
      apply_stimulus(1'b1, 3'd1, 8'hFF, 8'h00, 1'b0, 1'b0, 0);
`endif
      apply_stimulus(1'b0, 3'd1, 8'h00, 8'h7F, 1'b0, 1'b0, 0);

      check("no_rd_wr_overlap", overlap_cnt, 0);
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   initial begin
      #500000;
      $display("[TB] FAIL global_timeout: got timeout, expected completion");
      $fatal(1, "[TB] simulation time limit reached");
   end

endmodule

// File: doc/mem_access_sequencer.md
MEM_ACCESS_SEQUENCER -- requirements
Module: mem_access_sequencer

Interface
REQ-001 Parameter: ADDR_W, 3, word address width (8 words).
REQ-002 Parameter: DATA_W, 8, word width.
REQ-003 clk  input  1  single clock; all state updates on posedge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 req_valid  input  1  host request present.
REQ-006 req_ready  output  1  sequencer can accept a request.
REQ-007 req_write  input  1  1 = write, 0 = read.
REQ-008 req_adr  input  ADDR_W  target word address.
REQ-009 req_data  input  DATA_W  write data; ignored for reads.
REQ-010 rsp_valid  output  1  response present.
REQ-011 rsp_ready  input  1  host accepts response.
REQ-012 rsp_data  output  DATA_W  read data; 0 for writes.
REQ-013 rsp_err  output  1  write-verify mismatch flag.
REQ-014 mem_read, mem_write  output  1 each  memory-side read and write strobes.
REQ-015 mem_adr  output  ADDR_W; mem_inputs  output  DATA_W  memory address and write data.
REQ-016 mem_outputs  input  DATA_W  memory read data, combinational from the memory's registered read enable.

Function
REQ-017 Request SHALL be accepted on a posedge with req_valid && req_ready; req_ready SHALL equal (state == IDLE).
REQ-018 On accept, req_write, req_adr, and req_data SHALL be latched; mem_adr and mem_inputs SHALL hold the latched values until the state returns to IDLE.
REQ-019 States: IDLE, WR_ISSUE, WR_HOLD, RD_ISSUE, RD_CAPT, RSP.
REQ-020 Transitions: IDLE->WR_ISSUE (write accept) or RD_ISSUE (read accept); WR_ISSUE->WR_HOLD; WR_HOLD->RSP; RD_ISSUE->RD_CAPT; RD_CAPT->RSP; RSP->IDLE when rsp_ready.
REQ-021 mem_write SHALL be 1 only in WR_ISSUE; mem_read SHALL be 1 only in RD_ISSUE; both SHALL be registered outputs and SHALL never be 1 in the same cycle.
REQ-022 WR_HOLD SHALL keep mem_adr and mem_inputs stable for the cycle in which the memory's delayed write enable is active.
REQ-023 The posedge ending RD_CAPT SHALL capture mem_outputs into rsp_data.
REQ-024 Every accepted request SHALL produce exactly one response; rsp_valid rises 3 cycles after the accept edge (no verify).
REQ-025 rsp_valid, rsp_data, and rsp_err SHALL be stable while rsp_valid && !rsp_ready; backpressure SHALL be unbounded.
REQ-026 The write response SHALL carry rsp_data = 0 and rsp_err = 0, except as modified under Configuration.
REQ-027 Address wrap: ADDR_W-bit address is used as-is; no overflow logic.
REQ-028 req_valid during a non-IDLE state SHALL be ignored (not queued).

Reset
REQ-029 rst_n low SHALL immediately force state = IDLE and set mem_read, mem_write, rsp_valid, and rsp_err to 0, mem_adr, mem_inputs, and rsp_data to 0, and req_ready to 1 after release.
REQ-030 Reset mid-operation SHALL abandon the transaction with no response; memory contents are outside this block's reset domain.

Configuration
REQ-031 Macro MEM_SEQ_WRITE_VERIFY_EN, when defined: WR_HOLD SHALL go to RD_ISSUE at the same address; RD_CAPT SHALL compare mem_outputs against the latched data; rsp_err SHALL be 1 on mismatch; rsp_data SHALL return the read-back value; write latency SHALL be 5 cycles.
REQ-032 Macro MEM_SEQ_WRITE_VERIFY_EN, when undefined: the behaviour in REQ-020 and REQ-026 applies; rsp_err SHALL be tied to 0.

Structure
REQ-033 Package mem_seq_pkg SHALL hold the state enum typedef, ADDR_W and DATA_W defaults, and latency constants (RD_LAT=3, WR_LAT=3, WR_VFY_LAT=5).
REQ-034 Sub-module mem_seq_rsp_reg SHALL implement the response holding register (rsp_valid, rsp_data, rsp_err, load/clear); the FSM stays in the top module.

Verification
REQ-035 Write adr 0 data 0x53, then read adr 0 -> write response at +3 cycles with rsp_data 0x00; read response at +3 cycles with rsp_data 0x53.
REQ-036 Write "Sindre" (0x53,0x69,0x6E,0x64,0x72,0x65) to adr 0-5, then read adr 5..0 -> data returned in reverse order, with req_valid held high throughout and one response per request.
REQ-037 Hold rsp_ready = 0 for 5 cycles after a read of adr 3 = 0x64 -> rsp_valid stays 1, rsp_data stays 0x64, req_ready stays 0; completion occurs the cycle after rsp_ready = 1.
REQ-038 Assert rst_n = 0 during WR_HOLD of write adr 2 = 0x6E -> all outputs are 0 asynchronously, no response is produced, and the next read is accepted normally.
REQ-039 With MEM_SEQ_WRITE_VERIFY_EN and a memory model with bit 7 of adr 1 stuck at 0, write 0xFF -> rsp_err = 1 and rsp_data = 0x7F at +5 cycles; without the macro -> rsp_err = 0 at +3 cycles.
REQ-040 Monitor every cycle -> assert that mem_read && mem_write never occurs.
